// File: rtl/recompute_dispatcher.sv
// Issue-side sequencer for the BISR recompute path. Holds the BIST fault map and,
// for every accepted activation vector, issues one registered
// (weight, left input, row, column) tuple per cycle for each faulty PE in row-major order.
module recompute_dispatcher #(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned ROWS      = 4,
    parameter int unsigned COLS      = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 map_load,
    input  logic [ROWS*COLS-1:0]                 map_in,
    input  logic [ROWS*COLS*WORD_SIZE-1:0]       weights_in,
    input  logic                                 act_valid,
    input  logic [ROWS*WORD_SIZE-1:0]            act_in,
    output logic                                 act_ready,
    output logic [WORD_SIZE-1:0]                 Weight,
    output logic [WORD_SIZE-1:0]                 LeftIn,
    output logic [ROWS-1:0]                      faulty_row,
    output logic [COLS-1:0]                      faulty_col,
    output logic                                 issue_valid,
    output logic                                 pass_done,
    output logic [$clog2(ROWS*COLS+1)-1:0]       fault_count
);

    localparam int unsigned N  = ROWS * COLS;
    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic {StIdle, StScan} state_e;

    state_e                    r_state, w_state_nxt;
    logic [N-1:0]              r_map;
    logic [N-1:0]              r_pending, w_pending_nxt;
    logic [ROWS*WORD_SIZE-1:0] r_act, w_act_nxt;
    logic [WORD_SIZE-1:0]      r_weight, w_weight_nxt;
    logic [WORD_SIZE-1:0]      r_left, w_left_nxt;
    logic [ROWS-1:0]           r_row, w_row_nxt;
    logic [COLS-1:0]           r_col, w_col_nxt;
    logic                      r_issue, w_issue_nxt;
    logic                      r_done, w_done_nxt;
    logic [CW-1:0]             r_count, w_pop;

    // Lowest set pending bit, with its operands and the pending mask it leaves behind
    logic                      w_found;
    logic [N-1:0]              w_pend_clr;
    logic [WORD_SIZE-1:0]      w_sel_weight;
    logic [WORD_SIZE-1:0]      w_sel_left;
    logic [ROWS-1:0]           w_sel_row;
    logic [COLS-1:0]           w_sel_col;

    assign act_ready   = (r_state == StIdle);
    assign Weight      = r_weight;
    assign LeftIn      = r_left;
    assign faulty_row  = r_row;
    assign faulty_col  = r_col;
    assign issue_valid = r_issue;
    assign pass_done   = r_done;
    assign fault_count = r_count;

    // Priority-select the lowest-index faulty PE still pending in this pass
    always_comb begin
        w_found      = 1'b0;
        w_pend_clr   = r_pending;
        w_sel_weight = '0;
        w_sel_left   = '0;
        w_sel_row    = '0;
        w_sel_col    = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (r_pending[i] && !w_found) begin
                w_found             = 1'b1;
                w_pend_clr[i]       = 1'b0;
                w_sel_weight        = weights_in[i*WORD_SIZE +: WORD_SIZE];
                w_sel_left          = r_act[(i/COLS)*WORD_SIZE +: WORD_SIZE];
                w_sel_row[i/COLS]   = 1'b1;
                w_sel_col[i%COLS]   = 1'b1;
            end
        end
    end

    // Popcount of the incoming map, captured alongside it on map_load
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < int'(N); i++) begin
            w_pop = w_pop + CW'(map_in[i]);
        end
    end

    // Next-state and next registered outputs; tuple fields default to idle, data holds
    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        w_act_nxt     = r_act;
        w_weight_nxt  = r_weight;
        w_left_nxt    = r_left;
        w_row_nxt     = '0;
        w_col_nxt     = '0;
        w_issue_nxt   = 1'b0;
        w_done_nxt    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (act_valid) begin
                    // Snapshot the map so a concurrent map_load only affects later passes
                    w_act_nxt     = act_in;
                    w_pending_nxt = r_map;
                    w_state_nxt   = StScan;
                end
            end
            StScan: begin
                if (w_found) begin
                    w_weight_nxt  = w_sel_weight;
                    w_left_nxt    = w_sel_left;
                    w_row_nxt     = w_sel_row;
                    w_col_nxt     = w_sel_col;
                    w_issue_nxt   = 1'b1;
                    w_pending_nxt = w_pend_clr;
                    if (w_pend_clr == '0) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = StIdle;
                    end
                end else begin
                    // Empty map: a single non-issuing cycle that still reports completion
                    w_done_nxt  = 1'b1;
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // Sequencer state and registered issue outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= StIdle;
            r_pending <= '0;
            r_act     <= '0;
            r_weight  <= '0;
            r_left    <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_issue   <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            r_act     <= w_act_nxt;
            r_weight  <= w_weight_nxt;
            r_left    <= w_left_nxt;
            r_row     <= w_row_nxt;
            r_col     <= w_col_nxt;
            r_issue   <= w_issue_nxt;
            r_done    <= w_done_nxt;
        end
    end

    // Fault map and its popcount, loadable in any state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_map   <= '0;
            r_count <= '0;
        end else if (map_load) begin
            r_map   <= map_in;
            r_count <= w_pop;
        end
    end

endmodule
